// File: rtl/stepper_phase_decoder_if.sv
// Bundles the coil observation inputs and the decoded motion outputs of the
// stepper phase decoder; the decoder takes the slave side.
interface stepper_phase_decoder_if #(
    parameter int POS_W = 16,
    parameter int PER_W = 16
);
    logic                    ena;
    logic [3:0]              coil_in;
    logic                    clr;
    logic signed [POS_W-1:0] position;
    logic                    dir;
    logic                    step_pulse;
    logic                    illegal;
    logic [1:0]              mode;
    logic [PER_W-1:0]        period;
    logic                    stall;

    modport master (
        output ena, coil_in, clr,
        input  position, dir, step_pulse, illegal, mode, period, stall
    );

    modport slave (
        input  ena, coil_in, clr,
        output position, dir, step_pulse, illegal, mode, period, stall
    );
endinterface

// File: rtl/stepper_phase_decoder.sv
// Decodes observed stepper coil drive into half-step position, direction,
// drive mode, step period and stall, with input sync and glitch filtering.
module stepper_phase_decoder #(
    parameter int POS_W     = 16,
    parameter int PER_W     = 16,
    parameter int FILT      = 2,
    parameter int STALL_CYC = 50000
) (
    input logic                    clk,
    input logic                    rst_n,
    stepper_phase_decoder_if.slave bus
);
    typedef enum logic {NOREF, TRACK} state_t;

    localparam logic [3:0]       FILT_N    = 4'(FILT);
    localparam logic [PER_W-1:0] STALL_THR = PER_W'(STALL_CYC);

    // Returns {valid, half-step index} for a coil pattern.
    function automatic logic [3:0] lut(input logic [3:0] p);
        case (p)
            4'b0001: lut = 4'b1000;
            4'b0011: lut = 4'b1001;
            4'b0010: lut = 4'b1010;
            4'b0110: lut = 4'b1011;
            4'b0100: lut = 4'b1100;
            4'b1100: lut = 4'b1101;
            4'b1000: lut = 4'b1110;
            4'b1001: lut = 4'b1111;
            default: lut = 4'b0000;
        endcase
    endfunction

    state_t                  state_q;
    logic [3:0]              s1_q, s2_q;
    logic [3:0]              cand_q, acc_q;
    logic [3:0]              cnt_q;
    logic [2:0]              ref_q;
    logic signed [POS_W-1:0] position_q;
    logic                    dir_q, step_pulse_q, illegal_q, stall_q;
    logic [1:0]              mode_q;
    logic [PER_W-1:0]        period_q, idle_q;

    logic                    accept, lut_vld, step_ok, take_step, stall_d;
    logic [2:0]              lut_idx, delta;
    logic signed [POS_W-1:0] delta_ext;
    logic [PER_W-1:0]        idle_d;

    always_comb begin
        accept             = (cnt_q >= FILT_N) && (cand_q != acc_q);
        {lut_vld, lut_idx} = lut(cand_q);
        delta              = lut_idx - ref_q;
        // Only +-1 and +-2 half-steps are physically plausible between samples.
        step_ok   = (delta == 3'd1) || (delta == 3'd2) || (delta == 3'd6) || (delta == 3'd7);
        take_step = accept && lut_vld && (state_q == TRACK) && step_ok;
        delta_ext = {{(POS_W-3){delta[2]}}, delta};
        idle_d    = take_step ? PER_W'(1) : ((&idle_q) ? idle_q : idle_q + PER_W'(1));
        stall_d   = (idle_d >= STALL_THR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= NOREF;
            s1_q         <= '0;
            s2_q         <= '0;
            cand_q       <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            ref_q        <= '0;
            position_q   <= '0;
            dir_q        <= 1'b0;
            step_pulse_q <= 1'b0;
            illegal_q    <= 1'b0;
            mode_q       <= 2'b00;
            period_q     <= '0;
            idle_q       <= '0;
            stall_q      <= 1'b0;
        end else if (!bus.ena) begin
            step_pulse_q <= 1'b0;
        end else begin
            s1_q <= bus.coil_in;
            s2_q <= s1_q;
            if (s2_q == cand_q) begin
                if (cnt_q < FILT_N) cnt_q <= cnt_q + 4'd1;
            end else begin
                cand_q <= s2_q;
                cnt_q  <= 4'd1;
            end

            step_pulse_q <= 1'b0;
            if (accept) begin
                acc_q <= cand_q;
                if (cand_q == 4'b0000) begin
                    state_q <= NOREF;
                end else if (!lut_vld) begin
                    illegal_q <= 1'b1;
                end else if (state_q == NOREF) begin
                    ref_q   <= lut_idx;
                    state_q <= TRACK;
                end else begin
                    ref_q <= lut_idx;
                    if (step_ok) begin
                        step_pulse_q <= 1'b1;
                        dir_q        <= ~delta[2];
                        mode_q       <= delta[0] ? 2'b11 : (lut_idx[0] ? 2'b10 : 2'b01);
                        position_q   <= position_q + delta_ext;
                    end else begin
                        illegal_q <= 1'b1;
                    end
                end
            end

            if (take_step) period_q <= idle_q;
            idle_q  <= idle_d;
            stall_q <= stall_d;

            // Clear wins over a coincident step for position and error flag.
            if (bus.clr) begin
                position_q <= '0;
                illegal_q  <= 1'b0;
            end
        end
    end

    assign bus.position   = position_q;
    assign bus.dir        = dir_q;
    assign bus.step_pulse = step_pulse_q & bus.ena;
    assign bus.illegal    = illegal_q;
    assign bus.mode       = mode_q;
    assign bus.period     = period_q;
    assign bus.stall      = stall_q;
endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Scoreboard bench for stepper_phase_decoder: directed coil sequences push
// expected steps; a negedge monitor checks every step_pulse against them.
module tb_stepper_phase_decoder;
    localparam int FILT  = 2;
    localparam int STALL = 300;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    stepper_phase_decoder_if #(.POS_W(16), .PER_W(16)) bus ();

    stepper_phase_decoder #(
        .POS_W(16), .PER_W(16), .FILT(FILT), .STALL_CYC(STALL)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        int          cyc;
        logic [15:0] pos;
        logic        dir;
        logic [1:0]  mode;
        bit          chk_per;
        logic [15:0] per;
    } exp_t;

    exp_t       q[$];
    exp_t       e;
    int         cyc = 0;
    int         tests = 0;
    int         fails = 0;
    logic [3:0] tbl [8];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every pulse must match the oldest expectation; overdue ones are misses.
    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL missing_pulse: got none, expected pulse at cycle %0d (now %0d)", q[0].cyc, cyc);
            void'(q.pop_front());
        end
        if (bus.step_pulse === 1'b1) begin
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
            end else begin
                e = q.pop_front();
                chk("pulse_cycle", cyc, e.cyc);
                chk("position", $unsigned(bus.position), e.pos);
                chk("dir", bus.dir, e.dir);
                chk("mode", bus.mode, e.mode);
                chk("stall_at_pulse", bus.stall, 0);
                if (e.chk_per) chk("period", bus.period, e.per);
            end
        end
    end

    task automatic hold_pat(input logic [3:0] pat, input int hold);
        bus.coil_in = pat;
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic step(input logic [3:0] pat, input int hold, input logic [15:0] pos,
                        input logic d, input logic [1:0] m, input bit cp, input logic [15:0] per);
        bus.coil_in = pat;
        q.push_back('{cyc: cyc + 3 + FILT, pos: pos, dir: d, mode: m, chk_per: cp, per: per});
        repeat (hold) @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        bus.clr = 1'b1;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_position"}, $unsigned(bus.position), 0);
        chk({tag, "_dir"}, bus.dir, 0);
        chk({tag, "_step_pulse"}, bus.step_pulse, 0);
        chk({tag, "_illegal"}, bus.illegal, 0);
        chk({tag, "_mode"}, bus.mode, 0);
        chk({tag, "_period"}, bus.period, 0);
        chk({tag, "_stall"}, bus.stall, 0);
    endtask

    initial begin
        int          idx;
        logic [15:0] p;
        tbl = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
        rst_n       = 1'b0;
        bus.ena     = 1'b1;
        bus.clr     = 1'b0;
        bus.coil_in = 4'b0000;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset");
        rst_n = 1'b1;

        // Forward half-steps from index 0
        hold_pat(4'b0001, 10);
        step(4'b0011, 10, 16'd1, 1'b1, 2'b11, 0, 0);
        step(4'b0010, 10, 16'd2, 1'b1, 2'b11, 0, 0);
        step(4'b0110, 10, 16'd3, 1'b1, 2'b11, 0, 0);
        chk("fwd_position", $unsigned(bus.position), 16'd3);
        chk("fwd_mode", bus.mode, 2'b11);

        // Back to index 1, clear, then full-step reverse
        step(4'b0010, 10, 16'd2, 1'b0, 2'b11, 0, 0);
        step(4'b0011, 10, 16'd1, 1'b0, 2'b11, 0, 0);
        do_clr();
        chk("clr_position", $unsigned(bus.position), 16'd0);
        step(4'b1001, 10, 16'hFFFE, 1'b0, 2'b10, 0, 0);
        step(4'b1100, 10, 16'hFFFC, 1'b0, 2'b10, 0, 0);
        chk("rev_illegal", bus.illegal, 0);

        // Reach index 0, jump +3 (error), then +2 full step, then clear
        step(4'b1001, 10, 16'hFFFE, 1'b1, 2'b10, 0, 0);
        step(4'b0001, 10, 16'hFFFF, 1'b1, 2'b11, 0, 0);
        hold_pat(4'b0110, 10);
        chk("jump3_illegal", bus.illegal, 1);
        chk("jump3_position", $unsigned(bus.position), 16'hFFFF);
        step(4'b1100, 10, 16'h0001, 1'b1, 2'b10, 0, 0);
        chk("after_jump_illegal_sticky", bus.illegal, 1);
        do_clr();
        chk("clr2_position", $unsigned(bus.position), 16'd0);
        chk("clr2_illegal", bus.illegal, 0);
        chk("clr2_dir_kept", bus.dir, 1);
        chk("clr2_mode_kept", bus.mode, 2'b10);

        // De-energize, reference, glitch, re-reference at index 4
        hold_pat(4'b0000, 10);
        hold_pat(4'b0011, 10);
        hold_pat(4'b0010, 1);
        hold_pat(4'b0011, 10);
        hold_pat(4'b0000, 10);
        hold_pat(4'b0100, 10);
        chk("reref_illegal", bus.illegal, 0);
        chk("reref_position", $unsigned(bus.position), 16'd0);
        step(4'b0110, 10, 16'hFFFF, 1'b0, 2'b11, 0, 0);

        // Non-table pattern leaves reference at index 3
        hold_pat(4'b0101, 10);
        chk("badpat_illegal", bus.illegal, 1);
        chk("badpat_mode_kept", bus.mode, 2'b11);
        step(4'b0100, 100, 16'd0, 1'b1, 2'b11, 0, 0);
        step(4'b0110, 5, 16'hFFFF, 1'b0, 2'b11, 1, 16'd100);

        // Idle into stall at the exact threshold, then step clears it
        repeat (298) @(posedge clk);
        #1;
        chk("stall_before_thr", bus.stall, 0);
        @(posedge clk);
        #1;
        chk("stall_at_thr", bus.stall, 1);
        step(4'b0100, 10, 16'd0, 1'b1, 2'b11, 1, 16'd304);
        do_clr();
        chk("clr3_illegal", bus.illegal, 0);

        // Full steps forward up to the signed wrap
        step(4'b0110, 10, 16'hFFFF, 1'b0, 2'b11, 0, 0);
        do_clr();
        idx = 3;
        p   = 16'd0;
        for (int i = 0; i < 16383; i++) begin
            idx = (idx + 2) % 8;
            p   = p + 16'd2;
            step(tbl[idx], 3, p, 1'b1, 2'b10, 0, 0);
        end
        step(4'b0010, 10, 16'h7FFF, 1'b1, 2'b11, 0, 0);
        step(4'b0110, 10, 16'h8000, 1'b1, 2'b11, 1, 16'd10);
        chk("wrap_position", $unsigned(bus.position), 16'h8000);

        // Enable low freezes everything while coils move
        bus.ena = 1'b0;
        hold_pat(4'b0100, 10);
        hold_pat(4'b1100, 10);
        chk("ena0_position", $unsigned(bus.position), 16'h8000);
        chk("ena0_dir", bus.dir, 1);
        chk("ena0_mode", bus.mode, 2'b11);
        chk("ena0_period", bus.period, 16'd10);
        chk("ena0_step_pulse", bus.step_pulse, 0);
        bus.ena = 1'b1;
        step(4'b1100, 10, 16'h8002, 1'b1, 2'b10, 0, 0);

        // Reset in the middle of a pattern change
        bus.coil_in = 4'b1001;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_state("midreset");
        rst_n = 1'b1;
        hold_pat(4'b1001, 12);
        step(4'b0001, 10, 16'd1, 1'b1, 2'b11, 0, 0);

        repeat (10) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
